seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Iterative unsigned multiplier that consumes the ALU's mul1/mul2 operands and produces its mulresult.
//  The ALU sign-corrects operands before this block and the result after it, so this block is unsigned-only.
//  Shift-and-add, STEP multiplier bits per clock; a start/busy/done handshake lets the control FSM raise exec2.
// PARAMETERS
//  WIDTH  16  operand width; the result is 2*WIDTH bits
//  STEP   1   multiplier bits consumed per cycle; legal values 1, 2, 4; must divide WIDTH
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        request; sampled only when busy=0
//  mul1       in   WIDTH    multiplicand (unsigned), captured when start is accepted
//  mul2       in   WIDTH    multiplier (unsigned), captured when start is accepted
//  mulresult  out  2*WIDTH  product; registered, held stable until the next completion
//  busy       out  1        high from the acceptance edge until the completion edge
//  done       out  1        one-cycle pulse in the cycle after the completion edge
// BEHAVIOUR
//  Reset (async, any time, including mid-operation): state=IDLE, mulresult=0, busy=0, done=0.
//    The internal accumulator, operand registers and counter also clear. An in-flight operation is discarded.
//  Datapath registers:
//    acc 2*WIDTH; mcand 2*WIDTH (zero-extended mul1, shifts left STEP per iteration);
//    mplier WIDTH (shifts right STEP per iteration); cnt ceil(log2(WIDTH/STEP)) bits.
//  States:
//    IDLE: if start, capture operands, clear acc and cnt, set busy=1, go to RUN.
//    RUN:  each edge:
//      acc += mcand * mplier[STEP-1:0]  (partial product is at most STEP+2*WIDTH bits; truncate to 2*WIDTH, no overflow possible)
//      mcand <<= STEP; mplier >>= STEP; cnt++
//      Last iteration when cnt == WIDTH/STEP-1. On that edge: mulresult <= final acc, busy <= 0, done <= 1, go to DONE.
//    DONE: lasts exactly one cycle with done=1. start here is accepted exactly as in IDLE (back-to-back ops); otherwise go to IDLE.
//  Latency: start accepted at edge E0; completion at edge E(WIDTH/STEP); done high in the following cycle.
//    Defaults: 16 cycles.
//  start while busy=1 is ignored; it is not queued, and operand changes during RUN have no effect.
//  mulresult keeps the previous product throughout RUN and changes only on the completion edge.
//  done and busy are never high together. done is a pulse, not a level.
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined:
//    A RUN edge is also the completion edge when the post-shift mplier == 0. Latency = max(1, ceil(msb_index(mul2)+1)/STEP) cycles.
//    mul2==0 completes at E1 with product 0. Result values are identical to the fixed-latency build.
//  MUL_EARLY_EXIT_EN undefined:
//    Fixed latency of WIDTH/STEP cycles regardless of operand values.
// TESTING
//  1. mul1=3, mul2=5, 1-cycle start -> busy for 16 cycles, done pulse at cycle 16, mulresult=32'h0000000F.
//  2. mul1=16'hFFFF, mul2=16'hFFFF -> mulresult=32'hFFFE0001. Also 16'h8000*16'h0002 -> 32'h00010000.
//  3. start held high through RUN with operands changed to 7,7 at cycle 4 -> result still 15.
//     The second op starts only on the DONE-cycle start, giving 49 sixteen cycles later.
//  4. Assert rst_n=0 at cycle 8 of an op -> busy=0, done=0 and mulresult=0 immediately.
//     No done pulse follows. A new op then computes correctly.
//  5. MUL_EARLY_EXIT_EN: mul2=16'h0003, mul1=9 -> done at cycle 2, product 27. mul2=0 -> done at cycle 1, product 0.
//     Without the macro, both ops take 16 cycles and give the same products.
//  6. STEP=4: 16'h1234*16'h5678 -> 32'h06260060 after 4 cycles. Start asserted in the DONE cycle gives a back-to-back op with no gap.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative unsigned shift-and-add multiplier.
// Consumes STEP multiplier bits per clock and produces a 2*WIDTH-bit product.
// The start/busy/done handshake lets the ALU control FSM wait for the result.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero instead of always running WIDTH/STEP cycles.
// STEP must be 1, 2 or 4 and must divide WIDTH.
module seq_multiplier #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mul1,
    input  logic [WIDTH-1:0]     mul2,
    output logic [2*WIDTH-1:0]   mulresult,
    output logic                 busy,
    output logic                 done
);

    localparam int ITERS = WIDTH / STEP;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shift;
    logic                 last_iter;

    // One iteration of the datapath: add the partial product for the low STEP multiplier bits.
    always_comb begin
        // The true partial product is STEP bits wider, but the final product always fits in
        // 2*WIDTH bits, so evaluating the multiply at 2*WIDTH bits drops nothing that matters.
        partial      = mcand_q * {{(2*WIDTH-STEP){1'b0}}, mplier_q[STEP-1:0]};
        acc_sum      = acc_q + partial;
        mplier_shift = mplier_q >> STEP;
`ifdef MUL_EARLY_EXIT_EN
        last_iter    = (cnt_q == CNT_W'(ITERS-1)) || (mplier_shift == '0);
`else
        last_iter    = (cnt_q == CNT_W'(ITERS-1));
`endif
    end

    // Next-state and datapath update logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            // DONE accepts a new request exactly like IDLE so operations can run back-to-back.
            IDLE, DONE: begin
                if (start) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mul1};
                    mplier_d = mul2;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = acc_sum;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // busy and done decode directly from the state register, so they can never overlap.
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign mulresult = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: vector table, random ops against an arithmetic
// model, and hand-written sequences for hold, back-to-back and mid-op reset.
// Two instances are used: STEP=1 (u_dut1) and STEP=4 (u_dut4), both WIDTH=16.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start1, start4;
    logic [15:0] a1, b1, a4, b4;
    logic [31:0] res1, res4;
    logic        busy1, busy4, done1, done4;

    bit          sel;
    logic [31:0] res_v;
    logic        busy_v, done_v;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
    } vec_t;

    seq_multiplier #(.WIDTH(16), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mul1(a1), .mul2(b1),
        .mulresult(res1), .busy(busy1), .done(done1)
    );

    seq_multiplier #(.WIDTH(16), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mul1(a4), .mul2(b4),
        .mulresult(res4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        res_v  = sel ? res4  : res1;
        busy_v = sel ? busy4 : busy1;
        done_v = sel ? done4 : done1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycles from the acceptance edge to the completion edge, from the operand alone.
    function automatic int exp_lat(input logic [15:0] b, input int step);
`ifdef MUL_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < 16; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + step) / step;
`else
        return 16 / step;
`endif
    endfunction

    task automatic drive(input bit s, input logic st, input logic [15:0] a, input logic [15:0] b);
        if (s) begin start4 = st; a4 = a; b4 = b; end
        else   begin start1 = st; a1 = a; b1 = b; end
    endtask

    // Waits (bounded) for done; reports cycles and whether mulresult held and busy/done never overlapped.
    task automatic wait_done(input logic [31:0] prev, output int n, output bit hold_ok);
        n = 0;
        hold_ok = 1'b1;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy_v && done_v) hold_ok = 1'b0;
            if (done_v) break;
            if (res_v !== prev || !busy_v) hold_ok = 1'b0;
        end
    endtask

    task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string nm);
        logic [31:0] prev;
        int          n;
        bit          hold_ok;
        @(negedge clk);
        sel = s;
        drive(s, 1'b1, a, b);
        @(posedge clk); #1;
        check({nm, " busy_at_accept"}, 64'(busy_v), 64'(1));
        prev = res_v;
        // Scramble operands after acceptance: they must have no effect.
        @(negedge clk);
        drive(s, 1'b0, 16'($urandom), 16'($urandom));
        wait_done(prev, n, hold_ok);
        check({nm, " done_seen"}, 64'(done_v), 64'(1));
        check({nm, " latency"}, 64'(n), 64'(exp_lat(b, s ? 4 : 1)));
        check({nm, " busy_at_done"}, 64'(busy_v), 64'(0));
        check({nm, " product"}, 64'(res_v), 64'(exp));
        check({nm, " hold_during_run"}, 64'(hold_ok), 64'(1));
        @(posedge clk); #1;
        check({nm, " done_is_pulse"}, 64'(done_v), 64'(0));
    endtask

    initial begin
        vec_t        vecs[8];
        int          n;
        int          chg;
        bit          hold_ok;
        bit          saw_done;
        logic [15:0] ra, rb;

        tests_run    = 0;
        tests_failed = 0;
        sel   = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[3] = '{16'h0009, 16'h0003, 32'h0000001B};
        vecs[4] = '{16'h0009, 16'h0000, 32'h00000000};
        vecs[5] = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[7] = '{16'h0000, 16'hFFFF, 32'h00000000};

        // Reset state.
        #12;
        check("reset busy1", 64'(busy1), 64'(0));
        check("reset done1", 64'(done1), 64'(0));
        check("reset result1", 64'(res1), 64'(0));
        check("reset result4", 64'(res4), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table on both step sizes.
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d_s1", i));
            run_op(1'b1, vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d_s4", i));
        end

        // Random operands against plain arithmetic; shifted multipliers vary the early-exit point.
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            run_op(1'(i % 2), ra, rb, 32'(ra) * 32'(rb), $sformatf("rand%0d", i));
        end

        // start held through RUN, operands changed mid-op; next op accepted only in DONE.
        @(negedge clk);
        sel = 1'b0;
        drive(1'b0, 1'b1, 16'd3, 16'd5);
        @(posedge clk); #1;
        chg = (exp_lat(16'd5, 1) > 4) ? 4 : 1;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done_v) break;
            if (n == chg) begin
                @(negedge clk);
                drive(1'b0, 1'b1, 16'd7, 16'd7);
            end
        end
        check("held_start latency", 64'(n), 64'(exp_lat(16'd5, 1)));
        check("held_start product", 64'(res_v), 64'(15));
        @(posedge clk); #1;
        check("held_start b2b busy", 64'(busy_v), 64'(1));
        check("held_start b2b done", 64'(done_v), 64'(0));
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        wait_done(32'd15, n, hold_ok);
        check("held_start second latency", 64'(n), 64'(exp_lat(16'd7, 1)));
        check("held_start second product", 64'(res_v), 64'(49));
        check("held_start second hold", 64'(hold_ok), 64'(1));

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h1111, 16'hFFFF);
        @(posedge clk); #1;
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(busy1), 64'(0));
        check("midreset done", 64'(done1), 64'(0));
        check("midreset result", 64'(res1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done1 || busy1) saw_done = 1'b1;
        end
        check("midreset no_done_after", 64'(saw_done), 64'(0));
        run_op(1'b0, 16'h00FF, 16'h0101, 32'h0000FFFF, "post_reset");

        // STEP=4 back-to-back: second start presented in the DONE cycle.
        @(negedge clk);
        sel = 1'b1;
        drive(1'b1, 1'b1, 16'h1234, 16'h5678);
        @(posedge clk); #1;
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        wait_done(32'h0000FFFF & res4, n, hold_ok);
        check("b2b4 first latency", 64'(n), 64'(exp_lat(16'h5678, 4)));
        check("b2b4 first product", 64'(res4), 64'(32'h06260060));
        @(negedge clk);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        @(posedge clk); #1;
        check("b2b4 no_gap busy", 64'(busy4), 64'(1));
        check("b2b4 no_gap done", 64'(done4), 64'(0));
        check("b2b4 result held", 64'(res4), 64'(32'h06260060));
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        wait_done(32'h06260060, n, hold_ok);
        check("b2b4 second latency", 64'(n), 64'(exp_lat(16'hFFFF, 4)));
        check("b2b4 second product", 64'(res4), 64'(32'hFFFE0001));
        check("b2b4 second hold", 64'(hold_ok), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
